mac_result_packer: RTL and testbench
====================================

// Module: mac_result_packer
// PURPOSE
//  Downstream stage of the 4-bit MAC unit. Captures each 11-bit signed mac_out on its out_valid pulse.
//  Adds a programmable bias, then scales and saturates each result to an 8-bit lane.
//  Packs PACK lanes into one word and buffers words in a small FIFO with a valid/ready output toward the writeback bus.
//  The MAC has no backpressure, so results arriving while the FIFO is full are dropped and flagged.
// PARAMETERS
//  IN_W        11  width of signed mac result
//  OUT_W        8  width of each packed signed lane
//  PACK         4  lanes per output word
//  FIFO_DEPTH   4  words buffered (power of 2)
//  SHIFT        0  arithmetic right shift applied after bias add (floor)
// PORTS
//  clk         in   1            rising-edge clock
//  reset       in   1            synchronous, active-high
//  mac_out     in   IN_W         signed MAC result
//  out_valid   in   1            mac_out valid this cycle (1-cycle pulse)
//  bias        in   IN_W         signed bias, sampled with each result
//  flush       in   1            emit partial word, zero-padded
//  word_data   out  PACK*OUT_W   FIFO head; lane 0 = bits [OUT_W-1:0]
//  word_valid  out  1            FIFO non-empty
//  word_ready  in   1            consumer accepts head this cycle
//  sat_flag    out  1            1-cycle pulse: last captured result saturated
//  drop_err    out  1            sticky: a completed word was discarded
// BEHAVIOUR
//  Reset: lane_idx=0, pack reg=0, FIFO empty, word_valid=0, word_data=0, sat_flag=0, drop_err=0.
//   Reset mid-word discards the partial word and all FIFO contents.
//  Datapath (per out_valid):
//   - sum = sext(mac_out)+sext(bias) at IN_W+1 bits, then sum>>>SHIFT.
//   - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - sat_flag=1 on the next cycle if clipping occurred.
//  Lane write:
//   - Result written into lane lane_idx at the capturing edge.
//   - lane_idx increments and wraps PACK-1 -> 0.
//  Word complete:
//   - On the lane PACK-1 write, the full word (including that lane) is pushed at the same edge.
//   - The pack register is cleared.
//   - word_valid is high the following cycle (1-cycle latency from the last result).
//  Flush:
//   - flush with lane_idx!=0 pushes the word with unwritten lanes 0, then lane_idx=0.
//   - flush with out_valid in the same cycle: the result is included first, then the push happens.
//   - flush with lane_idx==0 and no out_valid is a no-op.
//  Handshake:
//   - Pop when word_valid && word_ready.
//   - Push is accepted if FIFO not full OR a pop occurs in the same cycle.
//   - word_data is stable while word_valid && !word_ready.
//  Full: a push that is not accepted drops the word and sets drop_err (until reset). Lane counting continues.
//  Empty: word_valid=0, word_data=0, word_ready ignored.
// CONFIGURATION
//  MAC_PACK_RELU_EN defined:
//   - Negative saturated lanes are forced to 0.
//   - sat_flag covers positive clipping only.
//  Undefined: signed saturation only.
// STRUCTURE
//  Package mac_pkg: IN_W/OUT_W/PACK constants, lane_t/word_t typedefs, sat_to_lane() function. Shared with the MAC.
//  Sub-module mac_word_fifo: sync FIFO with DEPTH/WIDTH parameters, push/pop/full/empty, same-cycle push+pop when full.
// TESTING
//  1. bias=0, results 1,2,3,4, word_ready=1 -> word_data=0x04030201, word_valid high 1 cycle after the 4th result.
//  2. mac_out=300, bias=0 -> lane 0x7F, sat_flag pulse.
//     mac_out=-1024, bias=-5 -> lane 0x80, sat_flag pulse.
//     SHIFT=2, mac_out=13 -> lane 0x03.
//  3. word_ready=0, 5 words -> 4 held, 5th dropped, drop_err=1; drain returns the 4 words in order.
//  4. results 5,-3 then flush -> word 0x0000FD05, lane_idx=0.
//     flush with lane_idx==0 -> no push.
//  5. 3 results, reset, then 1,2,3,4 -> only 0x04030201 emitted.
//     FIFO full + pop + push in the same cycle -> no drop.
//  6. With MAC_PACK_RELU_EN: results -3,7,-128,1 -> 0x01000700, no sat_flag for negatives.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC constants, lane/word types and the lane saturation helper.
// Optional build macro: MAC_PACK_RELU_EN clamps negative lanes to zero.
package mac_pkg;
  localparam int IN_W  = 11;
  localparam int OUT_W = 8;
  localparam int PACK  = 4;

  localparam int LANE_MAX = 2**(OUT_W-1) - 1;
  localparam int LANE_MIN = -(2**(OUT_W-1));

  typedef logic [OUT_W-1:0]            lane_t;
  typedef logic [PACK-1:0][OUT_W-1:0]  word_t;

  typedef struct packed {
    lane_t lane;
    logic  sat;
  } sat_res_t;

  // Input is the biased, shifted sum at IN_W+1 bits.
  function automatic sat_res_t sat_to_lane(input logic signed [IN_W:0] v);
    sat_res_t r;
    r.lane = v[OUT_W-1:0];
    r.sat  = 1'b0;
    if (int'(v) > LANE_MAX) begin
      r.lane = lane_t'(LANE_MAX);
      r.sat  = 1'b1;
    end
`ifdef MAC_PACK_RELU_EN
    else if (int'(v) < 0) begin
      r.lane = '0;
    end
`else
    else if (int'(v) < LANE_MIN) begin
      r.lane = lane_t'(LANE_MIN);
      r.sat  = 1'b1;
    end
`endif
    return r;
  endfunction
endpackage

// File: rtl/mac_result_packer_if.sv
// Result-in / packed-word-out bus of the MAC result packer.
interface mac_result_packer_if;
  import mac_pkg::*;

  logic [IN_W-1:0] mac_out;
  logic            out_valid;
  logic [IN_W-1:0] bias;
  logic            flush;
  word_t           word_data;
  logic            word_valid;
  logic            word_ready;

  modport master (
    output mac_out, out_valid, bias, flush, word_ready,
    input  word_data, word_valid
  );

  modport slave (
    input  mac_out, out_valid, bias, flush, word_ready,
    output word_data, word_valid
  );
endinterface

// File: rtl/mac_word_fifo.sv
// Synchronous word FIFO; a push while full is taken if a pop happens in the same cycle.
module mac_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/mac_result_packer.sv
// Biases, scales and saturates MAC results into 8-bit lanes, packs them into words and buffers them.
// Optional build macro: MAC_PACK_RELU_EN (negative lanes forced to zero).
module mac_result_packer
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT      = 0
) (
  input  logic                clk,
  input  logic                reset,
  mac_result_packer_if.slave  bus,
  output logic                sat_flag,
  output logic                drop_err
);
  localparam int LIDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  logic [LIDX_W-1:0]  lane_q, lane_d;
  word_t              pack_q, pack_d, push_word;
  logic               sat_q, sat_d, drop_q, drop_d;
  logic               push, pop, full, empty;
  logic signed [IN_W:0] sum, sum_sh;
  sat_res_t           res;
  logic [PACK*OUT_W-1:0] fifo_dout;

  assign sum    = $signed({bus.mac_out[IN_W-1], bus.mac_out}) + $signed({bus.bias[IN_W-1], bus.bias});
  assign sum_sh = sum >>> SHIFT;
  assign res    = sat_to_lane(sum_sh);

  // A flush in the same cycle as a result sees the lane index after that write.
  always_comb begin
    pack_d = pack_q;
    lane_d = lane_q;
    push   = 1'b0;
    if (bus.out_valid) begin
      pack_d[lane_q] = res.lane;
      if (lane_q == LIDX_W'(PACK-1)) begin
        push   = 1'b1;
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
    if (bus.flush && lane_d != '0) begin
      push   = 1'b1;
      lane_d = '0;
    end
    push_word = pack_d;
    if (push) pack_d = '0;
  end

  assign pop    = bus.word_valid && bus.word_ready;
  assign sat_d  = bus.out_valid && res.sat;
  assign drop_d = drop_q | (push && full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      pack_q <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  mac_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PACK*OUT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_word),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.word_data  = fifo_dout;
  assign bus.word_valid = !empty;
  assign sat_flag       = sat_q;
  assign drop_err       = drop_q;
endmodule

// File: tb/tb_mac_result_packer.sv
// Scoreboard bench for mac_result_packer; build with MAC_PACK_RELU_EN to cover the ReLU variant.
module tb_mac_result_packer;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_result_packer_if bus();
  mac_result_packer_if bus2();
  logic sat_flag, drop_err, sat2, drop2;

  mac_result_packer #(.FIFO_DEPTH(4), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sat_flag(sat_flag), .drop_err(drop_err));
  mac_result_packer #(.FIFO_DEPTH(4), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .sat_flag(sat2), .drop_err(drop2));

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_lanes[4];
  int          m_idx;
  bit          m_sat, m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lane_of(input int m, input int b, input int sh, output bit sat);
    int v;
    v   = (m + b) >>> sh;
    sat = 1'b0;
    if (v > 127) begin v = 127; sat = 1'b1; end
    else if (v < 0) begin
`ifdef MAC_PACK_RELU_EN
      v = 0;
`else
      if (v < -128) begin v = -128; sat = 1'b1; end
`endif
    end
    return v[7:0];
  endfunction

  // Model update for the edge that just consumed the inputs.
  function automatic void step(input bit v, input int m, input int b, input bit fl);
    bit s, pw;
    logic [31:0] w;
    pw = 1'b0;
    m_sat = 1'b0;
    if (v) begin
      m_lanes[m_idx] = lane_of(m, b, 0, s);
      m_sat = s;
      if (m_idx == 3) begin pw = 1'b1; m_idx = 0; end
      else m_idx++;
    end
    if (fl && m_idx != 0) begin pw = 1'b1; m_idx = 0; end
    if (pw) begin
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = m_lanes[i];
      for (int i = 0; i < 4; i++) m_lanes[i] = '0;
      if (exp_q.size() < 4) exp_q.push_back(w);
      else m_drop = 1'b1;
    end
  endfunction

  // Pops here stand for the pop at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", bus.word_valid, exp_q.size() != 0);
      if (bus.word_valid && exp_q.size() != 0) begin
        chk("word", bus.word_data, exp_q[0]);
        if (bus.word_ready) void'(exp_q.pop_front());
      end else if (!bus.word_valid) begin
        chk("empty_data", bus.word_data, 32'h0);
      end
    end
  end

  task automatic send(input int m, input int b, input bit fl);
    bus.mac_out = m[10:0]; bus.bias = b[10:0]; bus.out_valid = 1'b1; bus.flush = fl;
    @(posedge clk);
    step(1'b1, m, b, fl);
    #1 bus.out_valid = 1'b0; bus.flush = 1'b0;
    chk("sat", sat_flag, m_sat);
    chk("drop", drop_err, m_drop);
  endtask

  task automatic flush_only();
    bus.flush = 1'b1;
    @(posedge clk);
    step(1'b0, 0, 0, 1'b1);
    #1 bus.flush = 1'b0;
    chk("sat_idle", sat_flag, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); step(1'b0, 0, 0, 1'b0); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete(); m_idx = 0; m_drop = 1'b0; m_sat = 1'b0;
    for (int i = 0; i < 4; i++) m_lanes[i] = '0;
    #1 reset = 1'b0;
    chk("rst_valid", bus.word_valid, 1'b0);
    chk("rst_data", bus.word_data, 32'h0);
    chk("rst_sat", sat_flag, 1'b0);
    chk("rst_drop", drop_err, 1'b0);
  endtask

  task automatic drain();
    bus.word_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", bus.word_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.mac_out = '0; bus.bias = '0; bus.out_valid = 1'b0; bus.flush = 1'b0; bus.word_ready = 1'b1;
    bus2.mac_out = '0; bus2.bias = '0; bus2.out_valid = 1'b0; bus2.flush = 1'b0; bus2.word_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Basic packing and 1-cycle latency from the last lane
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
    chk("t1_not_yet", bus.word_valid, 1'b0);
    send(4, 0, 0);
    chk("t1_valid", bus.word_valid, 1'b1);
    chk("t1_data", bus.word_data, 32'h04030201);
    idle(2);

    // Saturation
    send(300, 0, 1);
    chk("t2_pos_sat", sat_flag, 1'b1);
    chk("t2_pos_data", bus.word_data, 32'h0000007F);
    idle(1);
    chk("t2_sat_pulse", sat_flag, 1'b0);
    send(-1024, -5, 1);
`ifdef MAC_PACK_RELU_EN
    chk("t2_neg_sat", sat_flag, 1'b0);
    chk("t2_neg_data", bus.word_data, 32'h0);
`else
    chk("t2_neg_sat", sat_flag, 1'b1);
    chk("t2_neg_data", bus.word_data, 32'h00000080);
`endif
    idle(2);

    // Arithmetic shift on the SHIFT=2 instance
    bus2.mac_out = 11'd13; bus2.out_valid = 1'b1; bus2.flush = 1'b1;
    @(posedge clk); #1 bus2.out_valid = 1'b0; bus2.flush = 1'b0;
    chk("shift_valid", bus2.word_valid, 1'b1);
    chk("shift_pos", bus2.word_data, 32'h00000003);
    bus2.mac_out = 11'h7F3; bus2.out_valid = 1'b1; bus2.flush = 1'b1;
    @(posedge clk); #1 bus2.out_valid = 1'b0; bus2.flush = 1'b0;
`ifdef MAC_PACK_RELU_EN
    chk("shift_neg", bus2.word_data, 32'h0);
`else
    chk("shift_neg", bus2.word_data, 32'h000000FC);
`endif

    // Flush of a partial word, then flush with nothing pending
    send(5, 0, 0); send(-3, 0, 0);
    flush_only();
`ifdef MAC_PACK_RELU_EN
    chk("t4_flush", bus.word_data, 32'h00000005);
`else
    chk("t4_flush", bus.word_data, 32'h0000FD05);
`endif
    send(9, 0, 0);
    flush_only();
    chk("t4_lane0", bus.word_data, 32'h00000009);
    flush_only();
    chk("t4_noop", bus.word_valid, 1'b0);

    // Full FIFO with simultaneous pop and push: no drop
    bus.word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i + 16, 0, 0);
    send(40, 0, 0); send(41, 0, 0); send(42, 0, 0);
    bus.word_ready = 1'b1;
    send(43, 0, 0);
    chk("t5_no_drop", drop_err, 1'b0);
    bus.word_ready = 1'b0;
    idle(2);
    drain();

    // Overflow: fifth word dropped, first four drained in order
    bus.word_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(i - 10, 0, 0);
    chk("t3_drop", drop_err, 1'b1);
    chk("t3_held", exp_q.size(), 4);
    idle(3);
    drain();
    chk("t3_sticky", drop_err, 1'b1);

    // Reset mid-word discards the partial word
    send(7, 0, 0); send(8, 0, 0); send(9, 0, 0);
    do_reset();
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    chk("t5_after_rst", bus.word_data, 32'h04030201);
    drain();

`ifdef MAC_PACK_RELU_EN
    send(-3, 0, 0);
    chk("t6_sat_neg", sat_flag, 1'b0);
    send(7, 0, 0); send(-128, 0, 0);
    chk("t6_sat_min", sat_flag, 1'b0);
    send(1, 0, 0);
    chk("t6_relu", bus.word_data, 32'h01000700);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
